// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Brief    : RX line plus received-word outputs of the UART receiver.
// Revision : 1.0
// ============================================================================
interface uart_rx_if #(
  parameter int DATA_LENGTH = 8
);
  logic                   serial;
  logic [DATA_LENGTH-1:0] data;
  logic                   valid;
  logic                   parity_err;
  logic                   frame_err;
  logic                   busy;

  modport master (
    output serial,
    input  data, valid, parity_err, frame_err, busy
  );

  modport slave (
    input  serial,
    output data, valid, parity_err, frame_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : UART receiver, mid-symbol sampling, parity and framing checks.
// Revision : 1.0
// ============================================================================
`ifndef SYSCLK_FREQUENCY_HZ
`define SYSCLK_FREQUENCY_HZ 50000000
`endif
`ifndef BAUDRATE
`define BAUDRATE 115200
`endif
`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif
`ifndef DOUBLE_STOPBIT
`define DOUBLE_STOPBIT 0
`endif
`ifndef PARITY
`define PARITY 2'd0
`endif

module uart_rx #(
  parameter int         SYSCLK_FREQUENCY_HZ = `SYSCLK_FREQUENCY_HZ,
  parameter int         BAUDRATE            = `BAUDRATE,
  parameter int         DATA_LENGTH         = `DATA_LENGTH,
  parameter int         DOUBLE_STOPBIT      = `DOUBLE_STOPBIT,
  parameter logic [1:0] PARITY              = `PARITY
) (
  input wire logic sysclk,
  input wire logic rst_n,
  uart_rx_if.slave rx
);

  localparam int c_CYCLES = SYSCLK_FREQUENCY_HZ / BAUDRATE;
  localparam int c_CNT_W  = $clog2(c_CYCLES);
  localparam int c_IDX_W  = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_CYCLES / 2 - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_LENGTH - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic [1:0]             r_sync;
  logic                   w_rxs;
  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_IDX_W-1:0]     r_idx;
  logic [DATA_LENGTH-1:0] r_shift;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   w_tick;
  logic                   w_last_stop;
  logic                   w_ferr_nxt;
  logic                   w_par_exp;
  logic                   w_done;
  logic                   w_busy;
  logic [DATA_LENGTH-1:0] r_data;
  logic                   r_valid;
  logic                   r_parity_err;
  logic                   r_frame_err;

  // Synchroniser flops reset high so reset release never looks like a start bit.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], rx.serial};
  end
  assign w_rxs = r_sync[1];

  // Sample point: half a symbol into the start bit, full symbols thereafter.
  always_comb begin
    w_tick = 1'b0;
    case (r_state)
      S_START:                  w_tick = (r_cnt == c_CNT_HALF);
      S_DATA, S_PARITY, S_STOP: w_tick = (r_cnt == c_CNT_FULL);
      default:                  w_tick = 1'b0;
    endcase
  end

  assign w_last_stop = (DOUBLE_STOPBIT == 0) || (r_idx == c_IDX_ONE);
  assign w_ferr_nxt  = r_ferr | ~w_rxs;
  assign w_par_exp   = PARITY[0] ^ (^r_shift);
  assign w_done      = (r_state == S_STOP) && w_tick && w_last_stop;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (!w_rxs) w_state_nxt = S_START;
      S_START:     if (w_tick) w_state_nxt = w_rxs ? S_IDLE : S_DATA;
      S_DATA:
        if (w_tick && (r_idx == c_IDX_LAST))
          w_state_nxt = (PARITY != 2'd0) ? S_PARITY : S_STOP;
      S_PARITY:    if (w_tick) w_state_nxt = S_STOP;
      S_STOP:
        if (w_tick && w_last_stop)
          w_state_nxt = w_ferr_nxt ? S_WAIT_HIGH : S_IDLE;
      S_WAIT_HIGH: if (w_rxs) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      case (r_state)
        S_START, S_DATA, S_PARITY, S_STOP: r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        default:                           r_cnt <= '0;
      endcase

      if (r_state == S_IDLE) begin
        r_idx  <= '0;
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end else if (w_tick) begin
        case (r_state)
          S_DATA: begin
            r_shift[r_idx] <= w_rxs;
            r_idx          <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
          end
          S_PARITY: r_perr <= w_rxs ^ w_par_exp;
          S_STOP: begin
            r_ferr <= w_ferr_nxt;
            r_idx  <= r_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_data       <= r_shift;
        r_parity_err <= r_perr;
        r_frame_err  <= w_ferr_nxt;
      end
    end
  end

  assign rx.data       = r_data;
  assign rx.valid      = r_valid;
  assign rx.parity_err = r_parity_err;
  assign rx.frame_err  = r_frame_err;
  assign rx.busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed bench for uart_rx: 8N1 receiver and 8E2 receiver, C=16.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

  localparam int C = 16;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  int   vtot0 = 0;
  int   btot0 = 0;
  int   vtot1 = 0;
  int   etot1 = 0;
  logic [7:0] hist1 [0:15];

  always #5 sysclk = ~sysclk;

  uart_rx_if #(.DATA_LENGTH(8)) if0 ();
  uart_rx_if #(.DATA_LENGTH(8)) if1 ();

  uart_rx #(
    .SYSCLK_FREQUENCY_HZ(16000000), .BAUDRATE(1000000), .DATA_LENGTH(8),
    .DOUBLE_STOPBIT(0), .PARITY(2'd0)
  ) u_dut0 (
    .sysclk(sysclk), .rst_n(rst_n), .rx(if0)
  );

  uart_rx #(
    .SYSCLK_FREQUENCY_HZ(16000000), .BAUDRATE(1000000), .DATA_LENGTH(8),
    .DOUBLE_STOPBIT(1), .PARITY(2'b10)
  ) u_dut1 (
    .sysclk(sysclk), .rst_n(rst_n), .rx(if1)
  );

  always @(negedge sysclk) begin
    if (if0.valid) vtot0 <= vtot0 + 1;
    if (if0.busy)  btot0 <= btot0 + 1;
    if (if1.valid) begin
      hist1[vtot1[3:0]] <= if1.data;
      vtot1 <= vtot1 + 1;
      if (if1.parity_err || if1.frame_err) etot1 <= etot1 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int dut, input logic b, input int cycles);
    if (dut == 0) if0.serial = b;
    else          if1.serial = b;
    repeat (cycles) @(negedge sysclk);
  endtask

  task automatic send_frame(input int dut, input logic [7:0] d, input logic use_par,
                            input logic par, input int nstop, input logic stop_val);
    drive(dut, 1'b0, C);
    for (int i = 0; i < 8; i++) drive(dut, d[i], C);
    if (use_par) drive(dut, par, C);
    for (int i = 0; i < nstop; i++) drive(dut, stop_val, C);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data0"},  32'(if0.data), 32'h0);
    check({tag, "_valid0"}, 32'(if0.valid), 32'h0);
    check({tag, "_perr0"},  32'(if0.parity_err), 32'h0);
    check({tag, "_ferr0"},  32'(if0.frame_err), 32'h0);
    check({tag, "_busy0"},  32'(if0.busy), 32'h0);
    check({tag, "_data1"},  32'(if1.data), 32'h0);
  endtask

  initial begin
    int vb, bb, eb;
    if0.serial = 1'b1;
    if1.serial = 1'b1;
    rst_n      = 1'b0;
    repeat (3) @(negedge sysclk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    drive(0, 1'b1, 10);

    // 8N1 frame 0xA5
    vb = vtot0; bb = btot0;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1);
    drive(0, 1'b1, 2 * C);
    check("a5_valid_cnt", 32'(vtot0 - vb), 32'd1);
    check("a5_data",      32'(if0.data), 32'hA5);
    check("a5_perr",      32'(if0.parity_err), 32'h0);
    check("a5_ferr",      32'(if0.frame_err), 32'h0);
    check("a5_busy_cyc",  32'(btot0 - bb), 32'd152);

    // Even parity: correct, then wrong parity bit
    vb = vtot1;
    send_frame(1, 8'h3C, 1'b1, 1'b0, 2, 1'b1);
    drive(1, 1'b1, 2 * C);
    check("par_ok_cnt",  32'(vtot1 - vb), 32'd1);
    check("par_ok_data", 32'(if1.data), 32'h3C);
    check("par_ok_perr", 32'(if1.parity_err), 32'h0);
    vb = vtot1;
    send_frame(1, 8'h3C, 1'b1, 1'b1, 2, 1'b1);
    drive(1, 1'b1, 2 * C);
    check("par_bad_cnt",  32'(vtot1 - vb), 32'd1);
    check("par_bad_data", 32'(if1.data), 32'h3C);
    check("par_bad_perr", 32'(if1.parity_err), 32'h1);

    // Low stop bit followed by a 5-symbol break
    vb = vtot0;
    send_frame(0, 8'h96, 1'b0, 1'b0, 1, 1'b0);
    drive(0, 1'b0, 5 * C);
    drive(0, 1'b1, 4 * C);
    check("brk_valid_cnt", 32'(vtot0 - vb), 32'd1);
    check("brk_ferr",      32'(if0.frame_err), 32'h1);
    check("brk_data",      32'(if0.data), 32'h96);
    vb = vtot0;
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1, 1'b1);
    drive(0, 1'b1, 2 * C);
    check("post_brk_cnt",  32'(vtot0 - vb), 32'd1);
    check("post_brk_data", 32'(if0.data), 32'h5A);
    check("post_brk_ferr", 32'(if0.frame_err), 32'h0);

    // 4-cycle glitch on idle line
    vb = vtot0; bb = btot0;
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 3 * C);
    check("glitch_valid", 32'(vtot0 - vb), 32'd0);
    check("glitch_busy_cyc", 32'(btot0 - bb), 32'd8);
    check("glitch_busy_now", 32'(if0.busy), 32'h0);

    // Back-to-back frames, two stop bits, even parity
    vb = vtot1; eb = etot1;
    send_frame(1, 8'h00, 1'b1, 1'b0, 2, 1'b1);
    send_frame(1, 8'hFF, 1'b1, 1'b0, 2, 1'b1);
    drive(1, 1'b1, 3 * C);
    check("b2b_cnt",   32'(vtot1 - vb), 32'd2);
    check("b2b_data0", 32'(hist1[vb[3:0]]), 32'h00);
    vb = vb + 1;
    check("b2b_data1", 32'(hist1[vb[3:0]]), 32'hFF);
    check("b2b_errs",  32'(etot1 - eb), 32'd0);

    // Reset mid-data of 0x81, then a clean 0x42
    drive(0, 1'b0, C);
    drive(0, 1'b1, C);
    drive(0, 1'b0, C);
    drive(0, 1'b0, C / 2);
    rst_n = 1'b0;
    drive(0, 1'b1, 3);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    vb = vtot0;
    drive(0, 1'b1, 2 * C);
    send_frame(0, 8'h42, 1'b0, 1'b0, 1, 1'b1);
    drive(0, 1'b1, 2 * C);
    check("rst_frame_cnt",  32'(vtot0 - vb), 32'd1);
    check("rst_frame_data", 32'(if0.data), 32'h42);
    check("rst_frame_ferr", 32'(if0.frame_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
